// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: hazard FSM states and pipeline-boundary indices.
package cpu_pkg;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } hz_state_e;

  localparam int B_IF_ID   = 0;
  localparam int B_ID_EXE  = 1;
  localparam int B_EXE_MEM = 2;
  localparam int B_MEM_WB  = 3;

  // Load-use bubble count never exceeds 3, so two bits hold the remaining stall.
  localparam int LU_CNT_W = 2;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating statistics counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // NOTE: combinational blocks use blocking '=' with a default assigned first,
  // so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking '<=' so all
  // flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: per-boundary enables, bubble strobes and valid bits
// for load-use, redirect and memory-busy hazards, plus statistics counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int N_STAGES  = 5,
  parameter int BR_STAGE  = 2,
  parameter int LU_CYCLES = 1,
  parameter int RF_ADDR_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [RF_ADDR_W-1:0]  rs1_id,
  input  logic [RF_ADDR_W-1:0]  rs2_id,
  input  logic                  use_rs1_id,
  input  logic                  use_rs2_id,
  input  logic [RF_ADDR_W-1:0]  rd_ex,
  input  logic                  mem_read_ex,
  input  logic                  redirect,
  input  logic                  mem_busy,
  input  logic                  clr_stats,
  output logic                  pc_en,
  output logic [N_STAGES-2:0]   stage_en,
  output logic [N_STAGES-2:0]   bubble,
  output logic [N_STAGES-2:0]   valid,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int NB = N_STAGES - 1;
  // Boundaries up to and including the resolving one hold wrong-path work.
  localparam logic [NB-1:0] BR_MASK = NB'((1 << (BR_STAGE + 1)) - 1);

  logic [NB-1:0]       valid_d, valid_q, valid_sh;
  hz_state_e           state_d, state_q;
  logic [LU_CNT_W-1:0] lu_cnt_d, lu_cnt_q;
  logic                hz, redirect_ok;
  logic                cyc_inc, stall_inc, flush_inc;

  assign hz = valid_q[B_IF_ID] & valid_q[B_ID_EXE] & mem_read_ex & (rd_ex != '0) &
              ((use_rs1_id & (rs1_id == rd_ex)) | (use_rs2_id & (rs2_id == rd_ex)));

  assign redirect_ok = redirect & valid_q[BR_STAGE];
  assign valid_sh    = {valid_q[NB-2:0], 1'b1};

  always_comb begin
    pc_en     = 1'b0;
    stage_en  = '0;
    bubble    = '0;
    valid_d   = valid_q;
    state_d   = state_q;
    lu_cnt_d  = lu_cnt_q;
    cyc_inc   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (!arst_n) begin
      bubble = '1;
    end else if (!enable) begin
      // Frozen: nothing moves, nothing is counted.
    end else if (mem_busy) begin
      cyc_inc   = 1'b1;
      stall_inc = 1'b1;
    end else if (redirect_ok) begin
      pc_en     = 1'b1;
      stage_en  = '1;
      bubble    = BR_MASK;
      valid_d   = valid_sh & ~BR_MASK;
      state_d   = RUN;
      lu_cnt_d  = '0;
      cyc_inc   = 1'b1;
      flush_inc = 1'b1;
    end else if ((state_q == LU) || hz) begin
      stage_en           = '1;
      stage_en[B_IF_ID]  = 1'b0;
      bubble[B_ID_EXE]   = 1'b1;
      valid_d            = valid_sh;
      valid_d[B_IF_ID]   = valid_q[B_IF_ID];
      valid_d[B_ID_EXE]  = 1'b0;
      cyc_inc            = 1'b1;
      stall_inc          = 1'b1;
      if (state_q == RUN) begin
        if (LU_CYCLES > 1) begin
          state_d  = LU;
          lu_cnt_d = LU_CNT_W'(LU_CYCLES - 1);
        end
      end else begin
        lu_cnt_d = lu_cnt_q - 1'b1;
        if (lu_cnt_q == LU_CNT_W'(1)) begin
          state_d = RUN;
        end
      end
    end else begin
      pc_en    = 1'b1;
      stage_en = '1;
      valid_d  = valid_sh;
      cyc_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      valid_q  <= '0;
      state_q  <= RUN;
      lu_cnt_q <= '0;
    end else begin
      valid_q  <= valid_d;
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign valid = valid_q;

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (clr_stats),
    .inc   (cyc_inc),
    .count (cycle_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (clr_stats),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (clr_stats),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: four builds (default, LU_CYCLES=3, LU_CYCLES=2, CNT_W=4) share one stimulus bus.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       arst_n;
  logic       enable;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       use_rs1_id, use_rs2_id, mem_read_ex;
  logic       redirect, mem_busy, clr_stats;

  logic        pc_en_1, pc_en_3, pc_en_2, pc_en_c;
  logic [3:0]  stage_en_1, stage_en_3, stage_en_2, stage_en_c;
  logic [3:0]  bubble_1, bubble_3, bubble_2, bubble_c;
  logic [3:0]  valid_1, valid_3, valid_2, valid_c;
  logic [31:0] cyc_1, stl_1, fls_1;
  logic [31:0] cyc_3, stl_3, fls_3;
  logic [31:0] cyc_2, stl_2, fls_2;
  logic [3:0]  cyc_c, stl_c, fls_c;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .mem_busy(mem_busy),
    .clr_stats(clr_stats), .pc_en(pc_en_1), .stage_en(stage_en_1), .bubble(bubble_1),
    .valid(valid_1), .cycle_cnt(cyc_1), .stall_cnt(stl_1), .flush_cnt(fls_1)
  );

  pipe_hazard_ctrl #(.LU_CYCLES(3)) u_lu3 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .mem_busy(mem_busy),
    .clr_stats(clr_stats), .pc_en(pc_en_3), .stage_en(stage_en_3), .bubble(bubble_3),
    .valid(valid_3), .cycle_cnt(cyc_3), .stall_cnt(stl_3), .flush_cnt(fls_3)
  );

  pipe_hazard_ctrl #(.LU_CYCLES(2)) u_lu2 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .mem_busy(mem_busy),
    .clr_stats(clr_stats), .pc_en(pc_en_2), .stage_en(stage_en_2), .bubble(bubble_2),
    .valid(valid_2), .cycle_cnt(cyc_2), .stall_cnt(stl_2), .flush_cnt(fls_2)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .arst_n(arst_n), .enable(enable),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .redirect(redirect), .mem_busy(mem_busy),
    .clr_stats(clr_stats), .pc_en(pc_en_c), .stage_en(stage_en_c), .bubble(bubble_c),
    .valid(valid_c), .cycle_cnt(cyc_c), .stall_cnt(stl_c), .flush_cnt(fls_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    enable      = 1'b1;
    mem_busy    = 1'b0;
    redirect    = 1'b0;
    clr_stats   = 1'b0;
    mem_read_ex = 1'b0;
    rd_ex       = '0;
    rs1_id      = '0;
    rs2_id      = '0;
    use_rs1_id  = 1'b0;
    use_rs2_id  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    enable = 1'b0;
    arst_n = 1'b0;
    tick();
    arst_n = 1'b1;
  endtask

  task automatic fill();
    enable = 1'b1;
    repeat (4) tick();
  endtask

  // ld rd in EX, ID instruction reads x5 through rs1.
  task automatic set_hz(input logic [4:0] rd);
    mem_read_ex = 1'b1;
    rd_ex       = rd;
    rs1_id      = 5'd5;
    use_rs1_id  = 1'b1;
    rs2_id      = 5'd7;
    use_rs2_id  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_valid [6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111};
    idle_inputs();
    arst_n = 1'b0;
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== {1'b0, 4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL reset_forced: got %b expected %b", {pc_en_1, stage_en_1, bubble_1}, 9'b0_0000_1111);
    end
    tick();
    checks++;
    if ({valid_1, cyc_1, stl_1, fls_1} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid %b cyc %0d stall %0d flush %0d expected all 0", valid_1, cyc_1, stl_1, fls_1);
    end
    arst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (valid_1 !== exp_valid[i]) begin
        errors++;
        $display("FAIL fill_valid[%0d]: got %b expected %b", i, valid_1, exp_valid[i]);
      end
    end
    checks++;
    if (cyc_1 !== 32'd6 || stl_1 !== 32'd0) begin
      errors++;
      $display("FAIL fill_counts: cyc %0d stall %0d expected 6 0", cyc_1, stl_1);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    fill();
    enable = 1'b0;
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== 9'b0) begin
      errors++;
      $display("FAIL freeze_outputs: got %b expected 0", {pc_en_1, stage_en_1, bubble_1});
    end
    tick();
    tick();
    checks++;
    if (valid_1 !== 4'b1111 || cyc_1 !== 32'd4) begin
      errors++;
      $display("FAIL freeze_hold: valid %b cyc %0d expected 1111 4", valid_1, cyc_1);
    end
    enable = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    fill();
    set_hz(5'd5);
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== {1'b0, 4'b1110, 4'b0010}) begin
      errors++;
      $display("FAIL lu_stall: got %b expected %b", {pc_en_1, stage_en_1, bubble_1}, 9'b0_1110_0010);
    end
    tick();
    idle_inputs();
    settle();
    checks++;
    if (valid_1 !== 4'b1101 || stl_1 !== 32'd1 || pc_en_1 !== 1'b1) begin
      errors++;
      $display("FAIL lu_after: valid %b stall %0d pc_en %b expected 1101 1 1", valid_1, stl_1, pc_en_1);
    end
  endtask

  task automatic test_no_hazard();
    do_reset();
    fill();
    set_hz(5'd0);
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== {1'b1, 4'b1111, 4'b0000}) begin
      errors++;
      $display("FAIL x0_no_stall: got %b expected %b", {pc_en_1, stage_en_1, bubble_1}, 9'b1_1111_0000);
    end
    // rd matches rs1 but rs1 unused: still no hazard.
    rd_ex      = 5'd5;
    use_rs1_id = 1'b0;
    settle();
    checks++;
    if (pc_en_1 !== 1'b1) begin
      errors++;
      $display("FAIL unused_rs1: pc_en %b expected 1", pc_en_1);
    end
    // rs2 path match.
    rd_ex      = 5'd7;
    use_rs2_id = 1'b1;
    settle();
    checks++;
    if (pc_en_1 !== 1'b0 || bubble_1 !== 4'b0010) begin
      errors++;
      $display("FAIL rs2_hazard: pc_en %b bubble %b expected 0 0010", pc_en_1, bubble_1);
    end
    idle_inputs();
    tick();
    checks++;
    if (stl_1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_stall_cnt: got %0d expected 0", stl_1);
    end
  endtask

  task automatic test_lu3();
    int n_stall = 0;
    do_reset();
    fill();
    set_hz(5'd5);
    for (int i = 0; i < 8; i++) begin
      settle();
      if (pc_en_3 === 1'b0) n_stall++;
      tick();
      idle_inputs();
    end
    checks++;
    if (n_stall !== 3 || stl_3 !== 32'd3) begin
      errors++;
      $display("FAIL lu3_cycles: stalls %0d stall_cnt %0d expected 3 3", n_stall, stl_3);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fill();
    set_hz(5'd5);
    redirect = 1'b1;
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== {1'b1, 4'b1111, 4'b0111}) begin
      errors++;
      $display("FAIL redirect_hz: got %b expected %b", {pc_en_1, stage_en_1, bubble_1}, 9'b1_1111_0111);
    end
    tick();
    idle_inputs();
    checks++;
    if (fls_1 !== 32'd1 || stl_1 !== 32'd0 || valid_1 !== 4'b1000) begin
      errors++;
      $display("FAIL redirect_after: flush %0d stall %0d valid %b expected 1 0 1000", fls_1, stl_1, valid_1);
    end
    redirect = 1'b1;
    settle();
    checks++;
    if ({pc_en_1, stage_en_1, bubble_1} !== {1'b1, 4'b1111, 4'b0000}) begin
      errors++;
      $display("FAIL redirect_invalid: got %b expected %b", {pc_en_1, stage_en_1, bubble_1}, 9'b1_1111_0000);
    end
    tick();
    redirect = 1'b0;
    checks++;
    if (fls_1 !== 32'd1 || valid_1 !== 4'b0001) begin
      errors++;
      $display("FAIL redirect_ignored: flush %0d valid %b expected 1 0001", fls_1, valid_1);
    end
  endtask

  task automatic test_busy_lu2();
    do_reset();
    fill();
    set_hz(5'd5);
    settle();
    checks++;
    if (pc_en_2 !== 1'b0) begin
      errors++;
      $display("FAIL lu2_first: pc_en %b expected 0", pc_en_2);
    end
    tick();
    idle_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({pc_en_2, stage_en_2, bubble_2} !== 9'b0) begin
        errors++;
        $display("FAIL busy_hold[%0d]: got %b expected 0", i, {pc_en_2, stage_en_2, bubble_2});
      end
      tick();
    end
    mem_busy = 1'b0;
    settle();
    checks++;
    if ({pc_en_2, stage_en_2, bubble_2} !== {1'b0, 4'b1110, 4'b0010}) begin
      errors++;
      $display("FAIL lu2_resume: got %b expected %b", {pc_en_2, stage_en_2, bubble_2}, 9'b0_1110_0010);
    end
    tick();
    settle();
    checks++;
    if (pc_en_2 !== 1'b1 || stl_2 !== 32'd6 || cyc_2 !== 32'd10) begin
      errors++;
      $display("FAIL lu2_done: pc_en %b stall %0d cyc %0d expected 1 6 10", pc_en_2, stl_2, cyc_2);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    enable = 1'b1;
    repeat (20) tick();
    checks++;
    if (cyc_c !== 4'd15 || stl_c !== 4'd0) begin
      errors++;
      $display("FAIL cnt_saturate: cyc %0d stall %0d expected 15 0", cyc_c, stl_c);
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    checks++;
    if (cyc_c !== 4'd0) begin
      errors++;
      $display("FAIL cnt_clear: got %0d expected 0", cyc_c);
    end
    tick();
    checks++;
    if (cyc_c !== 4'd1) begin
      errors++;
      $display("FAIL cnt_after_clear: got %0d expected 1", cyc_c);
    end
  endtask

  task automatic test_reset_mid_lu();
    do_reset();
    fill();
    set_hz(5'd5);
    tick();
    idle_inputs();
    settle();
    checks++;
    if (pc_en_3 !== 1'b0) begin
      errors++;
      $display("FAIL mid_lu_stall: pc_en %b expected 0", pc_en_3);
    end
    arst_n = 1'b0;
    settle();
    checks++;
    if ({pc_en_3, stage_en_3, bubble_3} !== {1'b0, 4'b0000, 4'b1111}) begin
      errors++;
      $display("FAIL mid_lu_forced: got %b expected %b", {pc_en_3, stage_en_3, bubble_3}, 9'b0_0000_1111);
    end
    tick();
    arst_n = 1'b1;
    settle();
    checks++;
    if (valid_3 !== 4'b0000 || pc_en_3 !== 1'b1 || stl_3 !== 32'd0) begin
      errors++;
      $display("FAIL mid_lu_reset: valid %b pc_en %b stall %0d expected 0000 1 0", valid_3, pc_en_3, stl_3);
    end
  endtask

  initial begin
    idle_inputs();
    arst_n = 1'b0;
    test_reset();
    test_freeze();
    test_load_use();
    test_no_hazard();
    test_lu3();
    test_redirect();
    test_busy_lu2();
    test_saturate();
    test_reset_mid_lu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
